rsa_reg_ctrl: RTL

Parametrised register bank and sequencing controller for the modular-exponentiation core.
- Sits between the SPI register interface (addr/wdata/write-strobe) and an external RSA core.
- Holds multi-byte operands P, E, M, CONST of width OPW and launches the core with a start/done handshake.
- Captures the result C, and exposes status, error, timeout and interrupt.

---
 rtl/rsa_pkg.sv | 34 +++
 rtl/rsa_reg_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA register bank / sequencer: register map,
// STATUS/CTRL bit positions and controller states.
package rsa_pkg;

  localparam int STATUS_A = 0;
  localparam int CTRL_A   = 1;

  localparam int ST_DONE   = 0;
  localparam int ST_BUSY   = 1;
  localparam int ST_ERR_WR = 2;
  localparam int ST_ERR_TO = 3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  // Byte banks follow STATUS and CTRL, NB bytes each: P, E, M, CONST, then C.
  localparam int BANK_P     = 0;
  localparam int BANK_E     = 1;
  localparam int BANK_M     = 2;
  localparam int BANK_CONST = 3;
  localparam int BANK_C     = 4;

  function automatic int bank_base(input int bank, input int nb);
    return 2 + bank * nb;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/rsa_reg_ctrl.sv
// Register bank and start/done sequencer for the modular-exponentiation core.
//
// state  | meaning
// IDLE   | operands writable, waiting for a CTRL start
// LAUNCH | core_start high for this single cycle, watchdog cleared
// WAIT   | waiting for core_done, watchdog counting
module rsa_reg_ctrl
  import rsa_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int REG_W   = 8,
  parameter int OPW     = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_wdata,
  input  logic              reg_wr,
  output logic [REG_W-1:0]  reg_rdata,
  output logic [REG_W-1:0]  status,
  output logic [OPW-1:0]    op_p,
  output logic [OPW-1:0]    op_e,
  output logic [OPW-1:0]    op_m,
  output logic [OPW-1:0]    op_const,
  output logic              core_start,
  input  logic              core_done,
  input  logic [OPW-1:0]    core_result,
  output logic              irq
);

  localparam int NB        = OPW / REG_W;
  localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             done_q, done_d;
  logic             err_wr_q, err_wr_d;
  logic             err_to_q, err_to_d;
  logic             irq_en_q, irq_en_d;
  logic [OPW-1:0]   c_q, c_d;
  logic [3:0][OPW-1:0] opr;
  logic [REG_W-1:0] status_v;

  int   addr_n;
  logic busy, ctrl_wr, op_addr, op_wr_ok, start_req, clear_req;

  assign addr_n    = int'(reg_addr);
  assign busy      = (state_q != IDLE);
  assign ctrl_wr   = reg_wr && (addr_n == CTRL_A);
  assign op_addr   = (addr_n >= bank_base(BANK_P, NB)) && (addr_n < bank_base(BANK_C, NB));
  assign op_wr_ok  = reg_wr && op_addr && !busy;
  assign start_req = ctrl_wr && reg_wdata[CTRL_START];
  assign clear_req = ctrl_wr && reg_wdata[CTRL_CLEAR];

  for (genvar b = 0; b < 4; b++) begin : g_bank
    for (genvar i = 0; i < NB; i++) begin : g_byte
      localparam int A = bank_base(b, NB) + i;
      logic [REG_W-1:0] byte_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        byte_q <= '0;
        else if (op_wr_ok && addr_n == A)  byte_q <= reg_wdata;
      end
      assign opr[b][i*REG_W +: REG_W] = byte_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wd_q     <= '0;
      done_q   <= 1'b0;
      err_wr_q <= 1'b0;
      err_to_q <= 1'b0;
      irq_en_q <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      done_q   <= done_d;
      err_wr_q <= err_wr_d;
      err_to_q <= err_to_d;
      irq_en_q <= irq_en_d;
      c_q      <= c_d;
    end
  end

  // Clear is applied first so that events of the same cycle still land.
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    done_d   = done_q;
    err_wr_d = err_wr_q;
    err_to_d = err_to_q;
    irq_en_d = irq_en_q;
    c_d      = c_q;

    if (ctrl_wr) irq_en_d = reg_wdata[CTRL_IRQ_EN];
    if (clear_req) begin
      done_d   = 1'b0;
      err_wr_d = 1'b0;
      err_to_d = 1'b0;
    end
    if (busy && ((reg_wr && op_addr) || start_req)) err_wr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = LAUNCH;
          done_d  = 1'b0;
        end
      end
      LAUNCH: begin
        wd_d = '0;
        if (core_done) begin
          state_d = IDLE;
          c_d     = core_result;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (core_done) begin
          state_d = IDLE;
          c_d     = core_result;
          done_d  = 1'b1;
        end else if (TIMEOUT > 0 && wd_q == WD_LAST) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_v            = '0;
    status_v[ST_DONE]   = done_q;
    status_v[ST_BUSY]   = busy;
    status_v[ST_ERR_WR] = err_wr_q;
    status_v[ST_ERR_TO] = err_to_q;
  end

  always_comb begin
    reg_rdata = '0;
    if (addr_n == STATUS_A) reg_rdata = status_v;
    if (addr_n == CTRL_A)   reg_rdata[CTRL_IRQ_EN] = irq_en_q;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < NB; i++) begin
        if (addr_n == bank_base(b, NB) + i) reg_rdata = opr[b][i*REG_W +: REG_W];
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (addr_n == bank_base(BANK_C, NB) + i) reg_rdata = c_q[i*REG_W +: REG_W];
    end
  end

  assign status     = status_v;
  assign core_start = (state_q == LAUNCH);
  assign irq        = done_q & irq_en_q;
  assign op_p       = opr[BANK_P];
  assign op_e       = opr[BANK_E];
  assign op_m       = opr[BANK_M];
  assign op_const   = opr[BANK_CONST];

endmodule
